// File: rtl/mem_arbiter_resp.sv
// Arbitrates icache/dcache word requests onto one RAM port; data wins fetches.
// Define MEM_STARVE_GUARD_EN to bound how long a pending fetch can starve.
module mem_arbiter_resp #(
  parameter int TIMEOUT = 255
`ifdef MEM_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        merr
);

  typedef enum logic [1:0] {
    IDLE,
    ACC_I,
    ACC_D
  } state_e;

  localparam logic [1:0]  RS_BUSY   = 2'd1;
  localparam logic [1:0]  RS_ACCESS = 2'd2;
  localparam logic [1:0]  RS_ERROR  = 2'd3;
  localparam logic [31:0] BAD_WORD  = 32'hBAD1BAD1;
  localparam logic [7:0]  TO_CNT    = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic        wen_q, wen_d;
  logic        merr_q, merr_d;
  logic [7:0]  busy_q, busy_d;

  logic d_req;
  logic fin_ok;
  logic fin_err;
  logic trip;

  assign d_req   = dREN | dWEN;
  assign fin_ok  = (ramstate == RS_ACCESS);
  assign fin_err = !fin_ok &&
                   ((ramstate == RS_ERROR) ||
                    (busy_q == TO_CNT));
  assign merr    = merr_q;

`ifdef MEM_STARVE_GUARD_EN
  logic [2:0] starve_q, starve_d;

  assign trip = iREN &&
                (starve_q >= 3'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (d_req && !trip) begin
        if (iREN && starve_q != 3'h7)
          starve_d = starve_q + 3'd1;
      end else if (iREN) begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  assign trip = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    store_d  = store_q;
    wen_d    = wen_q;
    merr_d   = merr_q;
    busy_d   = busy_q;
    iwait    = 1'b1;
    iload    = '0;
    dwait    = 1'b1;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    // Saturating count of BUSY cycles seen by the open access
    if (state_q != IDLE &&
        ramstate == RS_BUSY &&
        busy_q != 8'hFF)
      busy_d = busy_q + 8'd1;

    unique case (state_q)
      IDLE: begin
        if (d_req && !trip) begin
          addr_d  = daddr;
          store_d = dstore;
          wen_d   = dWEN;
          busy_d  = '0;
          state_d = ACC_D;
        end else if (iREN) begin
          addr_d  = iaddr;
          store_d = '0;
          wen_d   = 1'b0;
          busy_d  = '0;
          state_d = ACC_I;
        end
      end
      ACC_I: begin
        ramREN  = 1'b1;
        ramaddr = addr_q;
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          unique case (1'b1)
            fin_ok: begin
              iwait   = 1'b0;
              iload   = ramload;
              state_d = IDLE;
            end
            fin_err: begin
              iwait   = 1'b0;
              iload   = BAD_WORD;
              merr_d  = 1'b1;
              state_d = IDLE;
            end
            default: ;
          endcase
        end
      end
      ACC_D: begin
        ramREN   = !wen_q;
        ramWEN   = wen_q;
        ramaddr  = addr_q;
        ramstore = store_q;
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          unique case (1'b1)
            fin_ok: begin
              dwait   = 1'b0;
              dload   = wen_q ? '0 : ramload;
              state_d = IDLE;
            end
            fin_err: begin
              dwait   = 1'b0;
              dload   = BAD_WORD;
              merr_d  = 1'b1;
              state_d = IDLE;
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wen_q   <= 1'b0;
      merr_q  <= 1'b0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wen_q   <= wen_d;
      merr_q  <= merr_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_resp.sv
// Randomized bench for mem_arbiter_resp against a word-memory reference.
// Build with MEM_STARVE_GUARD_EN to exercise the fetch starvation guard.
module tb_mem_arbiter_resp;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN, merr;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [1:0]  ramstate;

  int tests_run = 0;
  int failed    = 0;
  int busy_n    = 0;
  bit err_mode  = 1'b0;
  int acc_cyc   = 0;

  bit   [63:0] wr_valid;
  logic [31:0] wr_data [64];
  logic [31:0] ref_mem [64];

  localparam logic [31:0] BAD = 32'hBAD1BAD1;

  mem_arbiter_resp dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .merr(merr)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_word(input logic [5:0] i);
    if (i == 6'd16) return 32'h2402000A;
    return {i, 26'h0} ^ 32'h00C0FFEE ^ {26'h0, i};
  endfunction

  // RAM model: BUSY for busy_n cycles of an access, then ACCESS (or ERROR)
  assign ramload = wr_valid[ramaddr[7:2]] ? wr_data[ramaddr[7:2]]
                                          : init_word(ramaddr[7:2]);

  always_comb begin
    if (!(ramREN | ramWEN))    ramstate = 2'd0;
    else if (acc_cyc < busy_n) ramstate = 2'd1;
    else                       ramstate = err_mode ? 2'd3 : 2'd2;
  end

  always @(posedge CLK) begin
    acc_cyc <= (ramREN | ramWEN) ? acc_cyc + 1 : 0;
    if (ramWEN && ramstate == 2'd2) begin
      wr_valid[ramaddr[7:2]] <= 1'b1;
      wr_data[ramaddr[7:2]]  <= ramstore;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    iREN = 0; dREN = 0; dWEN = 0;
    busy_n = 0; err_mode = 0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  // Runs one request to completion; reports latency, load and anomalies
  task automatic xact(input bit is_d, input bit wen,
                      input logic [31:0] a, input logic [31:0] s,
                      input int busy, input bit err,
                      output int lat, output logic [31:0] ld,
                      output int strb, output bit bad);
    lat = -1; ld = '0; strb = 0; bad = 1'b0;
    step();
    busy_n = busy; err_mode = err;
    if (is_d) begin
      dREN = !wen; dWEN = wen; daddr = a; dstore = s;
    end else begin
      iREN = 1'b1; iaddr = a;
    end
    for (int c = 0; c < 400 && lat < 0; c++) begin
      @(negedge CLK);
      if (ramREN | ramWEN) begin
        strb++;
        if (ramaddr !== a) bad = 1'b1;
        if (ramWEN !== (is_d && wen)) bad = 1'b1;
        if (ramREN !== !(is_d && wen)) bad = 1'b1;
        if (is_d && wen && ramstore !== s) bad = 1'b1;
      end
      if (is_d && (iwait !== 1'b1 || iload !== '0)) bad = 1'b1;
      if (!is_d && (dwait !== 1'b1 || dload !== '0)) bad = 1'b1;
      if ((is_d ? dwait : iwait) === 1'b0) begin
        lat = c;
        ld  = is_d ? dload : iload;
      end
      step();
      iaddr = $urandom; daddr = $urandom; dstore = $urandom;
    end
    iREN = 0; dREN = 0; dWEN = 0;
  endtask

  task automatic test_reset();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    nRST = 1'b0;
    #3;
    tests_run++;
    if (iwait !== 1'b1 || dwait !== 1'b1) begin
      failed++;
      $display("FAIL reset_wait got i=%b d=%b want 1 1", iwait, dwait);
    end
    tests_run++;
    if (iload !== '0 || dload !== '0) begin
      failed++;
      $display("FAIL reset_load got %h %h want 0 0", iload, dload);
    end
    tests_run++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 ||
        ramaddr !== '0 || ramstore !== '0) begin
      failed++;
      $display("FAIL reset_ram got %b%b %h %h want zeros",
               ramREN, ramWEN, ramaddr, ramstore);
    end
    tests_run++;
    if (merr !== 1'b0) begin
      failed++;
      $display("FAIL reset_merr got %b want 0", merr);
    end
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_ifetch();
    int lat, strb; logic [31:0] ld; bit bad;
    xact(0, 0, 32'h40, '0, 0, 0, lat, ld, strb, bad);
    tests_run++;
    if (lat !== 1) begin
      failed++; $display("FAIL ifetch_lat got %0d want 1", lat);
    end
    tests_run++;
    if (ld !== 32'h2402000A) begin
      failed++; $display("FAIL ifetch_load got %h want 2402000a", ld);
    end
    tests_run++;
    if (strb !== 1 || bad) begin
      failed++; $display("FAIL ifetch_strobe got %0d bad=%b want 1 0", strb, bad);
    end
    @(negedge CLK);
    tests_run++;
    if (ramREN !== 1'b0 || iwait !== 1'b1) begin
      failed++; $display("FAIL ifetch_idle got ren=%b iwait=%b want 0 1", ramREN, iwait);
    end
  endtask

  task automatic test_random();
    int lat, strb, busy; logic [31:0] ld, s, a, exp; bit bad, is_d, wen;
    logic [5:0] idx;
    for (int n = 0; n < 20; n++) begin
      is_d = 1'($urandom_range(0, 1));
      wen  = is_d && 1'($urandom_range(0, 1));
      idx  = 6'($urandom_range(0, 63));
      a    = {24'h0, idx, 2'b00};
      s    = $urandom;
      busy = $urandom_range(0, 5);
      exp  = wen ? 32'h0 : ref_mem[idx];
      xact(is_d, wen, a, s, busy, 0, lat, ld, strb, bad);
      if (wen) ref_mem[idx] = s;
      tests_run++;
      if (lat !== busy + 1) begin
        failed++; $display("FAIL rand%0d_lat got %0d want %0d", n, lat, busy + 1);
      end
      tests_run++;
      if (ld !== exp) begin
        failed++; $display("FAIL rand%0d_load got %h want %h", n, ld, exp);
      end
      tests_run++;
      if (strb !== busy + 1 || bad) begin
        failed++; $display("FAIL rand%0d_bus got strb=%0d bad=%b want %0d 0", n, strb, bad, busy + 1);
      end
    end
    tests_run++;
    if (merr !== 1'b0) begin
      failed++; $display("FAIL rand_merr got %b want 0", merr);
    end
  endtask

  task automatic test_priority();
    step();
    busy_n = 0; err_mode = 0;
    iREN = 1; iaddr = 32'h44;
    dWEN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF;
    step();
    @(negedge CLK);
    tests_run++;
    if (ramWEN !== 1'b1 || ramaddr !== 32'h80 || ramstore !== 32'hDEADBEEF ||
        dwait !== 1'b0 || iwait !== 1'b1) begin
      failed++;
      $display("FAIL prio_data got wen=%b a=%h s=%h dw=%b iw=%b want 1 80 deadbeef 0 1",
               ramWEN, ramaddr, ramstore, dwait, iwait);
    end
    ref_mem[32] = 32'hDEADBEEF;
    step();
    dWEN = 0;
    @(negedge CLK);
    tests_run++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || iwait !== 1'b1) begin
      failed++; $display("FAIL prio_gap got %b%b iw=%b want 00 1", ramREN, ramWEN, iwait);
    end
    step();
    @(negedge CLK);
    tests_run++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h44 ||
        iwait !== 1'b0 || iload !== ref_mem[17]) begin
      failed++;
      $display("FAIL prio_fetch got ren=%b a=%h iw=%b ld=%h want 1 44 0 %h",
               ramREN, ramaddr, iwait, iload, ref_mem[17]);
    end
    step();
    iREN = 0;
    tests_run++;
    if (wr_data[32] !== 32'hDEADBEEF) begin
      failed++; $display("FAIL prio_ram got %h want deadbeef", wr_data[32]);
    end
  endtask

  task automatic test_busy3();
    int lat, strb; logic [31:0] ld; bit bad;
    xact(1, 0, 32'h80, '0, 3, 0, lat, ld, strb, bad);
    tests_run++;
    if (lat !== 4 || ld !== ref_mem[32]) begin
      failed++; $display("FAIL busy3 got lat=%0d ld=%h want 4 %h", lat, ld, ref_mem[32]);
    end
    tests_run++;
    if (merr !== 1'b0 || bad) begin
      failed++; $display("FAIL busy3_merr got %b bad=%b want 0 0", merr, bad);
    end
  endtask

  task automatic test_abort();
    step();
    busy_n = 10; err_mode = 0;
    dREN = 1; daddr = 32'h20;
    step();
    step();
    dREN = 0;
    @(negedge CLK);
    tests_run++;
    if (dwait !== 1'b1 || ramREN !== 1'b1) begin
      failed++; $display("FAIL abort_hold got dw=%b ren=%b want 1 1", dwait, ramREN);
    end
    step();
    @(negedge CLK);
    tests_run++;
    if (dwait !== 1'b1 || ramREN !== 1'b0) begin
      failed++; $display("FAIL abort_drop got dw=%b ren=%b want 1 0", dwait, ramREN);
    end
  endtask

  task automatic test_timeout();
    int lat, strb; logic [31:0] ld; bit bad;
    xact(1, 0, 32'h24, '0, 1000, 0, lat, ld, strb, bad);
    tests_run++;
    if (lat !== 256 || ld !== BAD) begin
      failed++; $display("FAIL timeout got lat=%0d ld=%h want 256 %h", lat, ld, BAD);
    end
    tests_run++;
    if (merr !== 1'b1) begin
      failed++; $display("FAIL timeout_merr got %b want 1", merr);
    end
    repeat (10) step();
    tests_run++;
    if (merr !== 1'b1) begin
      failed++; $display("FAIL merr_sticky got %b want 1", merr);
    end
  endtask

  task automatic test_error();
    int lat, strb; logic [31:0] ld; bit bad;
    do_reset();
    xact(0, 0, 32'h10, '0, 0, 1, lat, ld, strb, bad);
    tests_run++;
    if (lat !== 1 || ld !== BAD || merr !== 1'b1) begin
      failed++; $display("FAIL error_ack got lat=%0d ld=%h merr=%b want 1 %h 1", lat, ld, merr, BAD);
    end
  endtask

  task automatic test_starve();
    int i_acks, d_acks;
    byte seq [$];
    do_reset();
    i_acks = 0; d_acks = 0;
    step();
    busy_n = 0; err_mode = 0;
    iREN = 1; iaddr = 32'h40;
    dREN = 1; daddr = 32'h84;
    for (int c = 0; c < 50; c++) begin
      @(negedge CLK);
      if (iwait === 1'b0) begin i_acks++; seq.push_back("I"); end
      if (dwait === 1'b0) begin d_acks++; seq.push_back("D"); end
      step();
    end
    iREN = 0; dREN = 0;
`ifdef MEM_STARVE_GUARD_EN
    tests_run++;
    if (seq.size() !== 25) begin
      failed++; $display("FAIL starve_count got %0d want 25", seq.size());
    end
    for (int k = 0; k < seq.size(); k++) begin
      tests_run++;
      if (seq[k] !== ((k % 5 == 4) ? "I" : "D")) begin
        failed++; $display("FAIL starve_seq%0d got %c want %c", k, seq[k],
                           (k % 5 == 4) ? "I" : "D");
      end
    end
`else
    tests_run++;
    if (i_acks !== 0 || d_acks !== 25) begin
      failed++; $display("FAIL starve got i=%0d d=%0d want 0 25", i_acks, d_acks);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int lat, strb; logic [31:0] ld; bit bad;
    step();
    busy_n = 1000; err_mode = 0;
    dREN = 1; daddr = 32'h30;
    step();
    step();
    #2;
    nRST = 1'b0;
    #1;
    tests_run++;
    if (dwait !== 1'b1 || iwait !== 1'b1 || ramREN !== 1'b0 ||
        ramWEN !== 1'b0 || ramaddr !== '0 || merr !== 1'b0) begin
      failed++;
      $display("FAIL rst_mid got dw=%b iw=%b %b%b a=%h merr=%b want 1 1 00 0 0",
               dwait, iwait, ramREN, ramWEN, ramaddr, merr);
    end
    @(negedge CLK);
    nRST = 1'b1; dREN = 0;
    step();
    @(negedge CLK);
    tests_run++;
    if (ramREN !== 1'b0 || dwait !== 1'b1) begin
      failed++; $display("FAIL rst_idle got ren=%b dw=%b want 0 1", ramREN, dwait);
    end
    xact(0, 0, 32'h40, '0, 0, 0, lat, ld, strb, bad);
    tests_run++;
    if (lat !== 1 || ld !== ref_mem[16]) begin
      failed++; $display("FAIL rst_resume got lat=%0d ld=%h want 1 %h", lat, ld, ref_mem[16]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(6'(i));
    test_reset();
    test_ifetch();
    test_random();
    test_priority();
    test_busy3();
    test_abort();
    test_timeout();
    test_error();
    test_starve();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
